// File: rtl/spi_burst_pkg.sv
// -----------------------------------------------------------------------------
// spi_burst_pkg
// Shared definitions for the burst SPI master:
//   - spi_state_e  : transaction FSM states
//   - mode_cpol / mode_cpha : decode {CPOL,CPHA} from the SPI_MODE number
//   - count_width  : width of word-count ports for a given MAX_WORDS
//   - cs_width     : width of the chip-select index port (minimum 1)
// -----------------------------------------------------------------------------
package spi_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CS_SETUP  = 3'd1,
    ST_SHIFT     = 3'd2,
    ST_WORD_WAIT = 3'd3,
    ST_CS_HOLD   = 3'd4,
    ST_CS_GAP    = 3'd5
  } spi_state_e;

  // Bit positions inside the 2-bit SPI mode number.
  localparam int MODE_CPOL_BIT = 1;
  localparam int MODE_CPHA_BIT = 0;

  function automatic logic mode_cpol(input int mode);
    logic [1:0] m;
    m = 2'(mode);
    return m[MODE_CPOL_BIT];
  endfunction

  function automatic logic mode_cpha(input int mode);
    logic [1:0] m;
    m = 2'(mode);
    return m[MODE_CPHA_BIT];
  endfunction

  function automatic int count_width(input int max_words);
    return $clog2(max_words + 1);
  endfunction

  function automatic int cs_width(input int num_cs);
    return (num_cs > 1) ? $clog2(num_cs) : 1;
  endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// -----------------------------------------------------------------------------
// spi_sclk_gen
// Produces a burst of NUM_EDGES SCLK edges, each CLKS_PER_HALF_BIT i_clk
// cycles apart, after a one-cycle i_start request. SCLK rests at CPOL.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : begin a new burst (one cycle)
//   o_sclk         : serial clock
//   o_lead         : one-cycle strobe, asserted in the cycle SCLK shows a leading edge
//   o_trail        : one-cycle strobe, asserted in the cycle SCLK shows a trailing edge
//   o_done         : one-cycle strobe coinciding with the final edge of the burst
// -----------------------------------------------------------------------------
module spi_sclk_gen #(
  parameter logic CPOL              = 1'b0,
  parameter int   CLKS_PER_HALF_BIT = 4,
  parameter int   NUM_EDGES         = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  output logic o_sclk,
  output logic o_lead,
  output logic o_trail,
  output logic o_done
);

  localparam int HW = $clog2(CLKS_PER_HALF_BIT);
  localparam int EW = $clog2(NUM_EDGES + 1);
  localparam logic [HW-1:0] HALF_LAST   = HW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [EW-1:0] EDGES_TOTAL = EW'(NUM_EDGES);

  logic [HW-1:0] r_half_cnt;
  logic [EW-1:0] r_edges_left;
  logic          r_sclk;
  logic          r_lead;
  logic          r_trail;
  logic          r_done;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_half_cnt   <= '0;
      r_edges_left <= '0;
      r_sclk       <= CPOL;
      r_lead       <= 1'b0;
      r_trail      <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_lead  <= 1'b0;
      r_trail <= 1'b0;
      r_done  <= 1'b0;
      if (i_start) begin
        r_edges_left <= EDGES_TOTAL;
        r_half_cnt   <= '0;
        r_sclk       <= CPOL;
      end else if (r_edges_left != '0) begin
        if (r_half_cnt == HALF_LAST) begin
          r_half_cnt   <= '0;
          r_sclk       <= ~r_sclk;
          r_edges_left <= r_edges_left - EW'(1);
          // NUM_EDGES is even, so an even remaining count means the next
          // edge opens a new SCLK period (leading edge).
          if (r_edges_left[0] == 1'b0) r_lead  <= 1'b1;
          else                         r_trail <= 1'b1;
          if (r_edges_left == EW'(1))  r_done  <= 1'b1;
        end else begin
          r_half_cnt <= r_half_cnt + HW'(1);
        end
      end
    end
  end

  assign o_sclk  = r_sclk;
  assign o_lead  = r_lead;
  assign o_trail = r_trail;
  assign o_done  = r_done;

endmodule

// File: rtl/spi_master_burst.sv
// -----------------------------------------------------------------------------
// spi_master_burst
// SPI master that moves a burst of up to MAX_WORDS words under a single
// chip-select assertion. Words are handed in one at a time with a valid/ready
// pair; each received word is reported with its 0-based index in the burst.
//
// Optional build macro:
//   SPI_MASTER_BURST_LSB_FIRST_EN : shift and receive LSB first (default MSB first)
//
// Ports:
//   i_clk, i_rst_n           : system clock, asynchronous active-low reset
//   i_tx_word, i_tx_dataval  : next word to send and its one-cycle valid
//   o_tx_ready               : master can accept i_tx_dataval
//   i_tx_count, i_cs_sel     : burst length and target select (sampled with first word)
//   o_rx_dataval             : one-cycle pulse with o_rx_word / o_rx_count
//   o_SPI_clk, o_SPI_MOSI, i_SPI_MISO, o_SPI_CS_n : SPI bus
// -----------------------------------------------------------------------------
module spi_master_burst
  import spi_burst_pkg::*;
#(
  parameter int SPI_MODE          = 3,
  parameter int CLKS_PER_HALF_BIT = 4,
  parameter int DATA_WIDTH        = 8,
  parameter int MAX_WORDS         = 16,
  parameter int NUM_CS            = 2,
  parameter int CS_INACTIVE_CLKS  = 8
) (
  input  logic                                i_clk,
  input  logic                                i_rst_n,
  input  logic [DATA_WIDTH-1:0]               i_tx_word,
  input  logic                                i_tx_dataval,
  output logic                                o_tx_ready,
  input  logic [count_width(MAX_WORDS)-1:0]   i_tx_count,
  input  logic [cs_width(NUM_CS)-1:0]         i_cs_sel,
  output logic                                o_rx_dataval,
  output logic [DATA_WIDTH-1:0]               o_rx_word,
  output logic [count_width(MAX_WORDS)-1:0]   o_rx_count,
  output logic                                o_SPI_clk,
  input  logic                                i_SPI_MISO,
  output logic                                o_SPI_MOSI,
  output logic [NUM_CS-1:0]                   o_SPI_CS_n
);

  localparam logic CPOL = mode_cpol(SPI_MODE);
  localparam logic CPHA = mode_cpha(SPI_MODE);
  localparam int   CW   = count_width(MAX_WORDS);
  localparam int   BW   = $clog2(DATA_WIDTH + 1);
  localparam int   TMAX = (CLKS_PER_HALF_BIT > CS_INACTIVE_CLKS) ? CLKS_PER_HALF_BIT
                                                                 : CS_INACTIVE_CLKS;
  localparam int   TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_HALF_BIT - 1);
  localparam logic [TW-1:0] GAP_LAST  = TW'((CS_INACTIVE_CLKS > 0) ? CS_INACTIVE_CLKS - 1 : 0);

`ifdef SPI_MASTER_BURST_LSB_FIRST_EN
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return w[0];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
    return {1'b0, w[DATA_WIDTH-1:1]};
  endfunction
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b);
    return {b, w[DATA_WIDTH-1:1]};
  endfunction
`else
  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return w[DATA_WIDTH-1];
  endfunction
  function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w);
    return {w[DATA_WIDTH-2:0], 1'b0};
  endfunction
  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b);
    return {w[DATA_WIDTH-2:0], b};
  endfunction
`endif

  // Zero means a single word; anything above MAX_WORDS is capped.
  function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] c);
    if (c == '0)                 return CW'(1);
    else if (c > CW'(MAX_WORDS)) return CW'(MAX_WORDS);
    else                         return c;
  endfunction

  spi_state_e             r_state;
  spi_state_e             w_next;
  logic [TW-1:0]          r_cnt;
  logic [DATA_WIDTH-1:0]  r_tx_shift;
  logic [DATA_WIDTH-1:0]  r_rx_shift;
  logic                   r_mosi;
  logic [NUM_CS-1:0]      r_cs_n;
  logic                   r_tx_ready;
  logic [CW-1:0]          r_words_total;
  logic [CW-1:0]          r_word_idx;
  logic [BW-1:0]          r_bit_idx;
  logic                   r_rx_dataval;
  logic [DATA_WIDTH-1:0]  r_rx_word;
  logic [CW-1:0]          r_rx_count;

  logic w_accept;
  logic w_cs_ok;
  logic w_load;
  logic w_start;
  logic w_cnt_clr;
  logic w_lead;
  logic w_trail;
  logic w_done;
  logic w_sample;
  logic w_emit;
  logic w_sclk;

  spi_sclk_gen #(
    .CPOL              (CPOL),
    .CLKS_PER_HALF_BIT (CLKS_PER_HALF_BIT),
    .NUM_EDGES         (2 * DATA_WIDTH)
  ) u_sclk_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_start (w_start),
    .o_sclk  (w_sclk),
    .o_lead  (w_lead),
    .o_trail (w_trail),
    .o_done  (w_done)
  );

  // Acceptance is qualified by the registered ready so nothing is taken in
  // the first cycle after reset release or while a word is in flight.
  assign w_accept = i_tx_dataval && r_tx_ready;
  assign w_cs_ok  = (32'(i_cs_sel) < NUM_CS);
  assign w_sample = CPHA ? w_trail : w_lead;
  assign w_emit   = CPHA ? w_lead  : w_trail;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_start   = 1'b0;
    w_cnt_clr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && w_cs_ok) begin
          w_next    = ST_CS_SETUP;
          w_load    = 1'b1;
          w_cnt_clr = 1'b1;
        end
      end
      // Also used as the half-bit settle time before each later word.
      ST_CS_SETUP: begin
        if (r_cnt == HALF_LAST) begin
          w_next  = ST_SHIFT;
          w_start = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_done) begin
          w_cnt_clr = 1'b1;
          w_next    = (r_word_idx == r_words_total - CW'(1)) ? ST_CS_HOLD : ST_WORD_WAIT;
        end
      end
      ST_WORD_WAIT: begin
        if (w_accept) begin
          w_next    = ST_CS_SETUP;
          w_load    = 1'b1;
          w_cnt_clr = 1'b1;
        end
      end
      ST_CS_HOLD: begin
        if (r_cnt == HALF_LAST) begin
          w_next    = ST_CS_GAP;
          w_cnt_clr = 1'b1;
        end
      end
      ST_CS_GAP: begin
        if (r_cnt == GAP_LAST) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt         <= '0;
      r_tx_shift    <= '0;
      r_rx_shift    <= '0;
      r_mosi        <= 1'b0;
      r_cs_n        <= '1;
      r_tx_ready    <= 1'b0;
      r_words_total <= '0;
      r_word_idx    <= '0;
      r_bit_idx     <= '0;
      r_rx_dataval  <= 1'b0;
      r_rx_word     <= '0;
      r_rx_count    <= '0;
    end else begin
      r_rx_dataval <= 1'b0;
      r_tx_ready   <= (w_next == ST_IDLE) || (w_next == ST_WORD_WAIT);

      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (r_state == ST_CS_SETUP || r_state == ST_CS_HOLD || r_state == ST_CS_GAP) begin
        r_cnt <= r_cnt + TW'(1);
      end

      if (w_load) begin
        // CPHA=0 must present the first bit before the first edge; CPHA=1
        // re-emits it on the leading edge, so the word is kept unshifted.
        r_tx_shift <= CPHA ? i_tx_word : shift_out(i_tx_word);
        r_mosi     <= first_bit(i_tx_word);
        r_bit_idx  <= '0;
        if (r_state == ST_IDLE) begin
          r_words_total <= clamp_count(i_tx_count);
          r_word_idx    <= '0;
          r_cs_n        <= ~(NUM_CS'(1) << i_cs_sel);
        end else begin
          r_word_idx <= r_word_idx + CW'(1);
        end
      end

      if (r_state == ST_SHIFT) begin
        if (w_emit) begin
          r_mosi     <= first_bit(r_tx_shift);
          r_tx_shift <= shift_out(r_tx_shift);
        end
        if (w_sample) begin
          r_rx_shift <= shift_in(r_rx_shift, i_SPI_MISO);
          r_bit_idx  <= r_bit_idx + BW'(1);
          if (r_bit_idx == BW'(DATA_WIDTH - 1)) begin
            r_rx_dataval <= 1'b1;
            r_rx_word    <= shift_in(r_rx_shift, i_SPI_MISO);
            r_rx_count   <= r_word_idx;
          end
        end
      end

      if (r_state == ST_CS_HOLD && w_next == ST_CS_GAP) begin
        r_cs_n <= '1;
      end
    end
  end

  assign o_tx_ready   = r_tx_ready;
  assign o_rx_dataval = r_rx_dataval;
  assign o_rx_word    = r_rx_word;
  assign o_rx_count   = r_rx_count;
  assign o_SPI_clk    = w_sclk;
  assign o_SPI_MOSI   = r_mosi;
  assign o_SPI_CS_n   = r_cs_n;

endmodule

// File: tb/tb_spi_master_burst.sv
// -----------------------------------------------------------------------------
// tb_spi_master_burst
// Two instances: A = mode 3, 8-bit, 2 selects, MOSI looped to MISO.
//                B = mode 0, 16-bit, 3 selects (2-bit select port, so an
//                    out-of-range index can be expressed), MOSI looped back.
// Expected received words are queued when stimulus is issued and popped by
// per-instance monitors on each o_rx_dataval pulse.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master_burst;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] idx;
  } exp_t;

  localparam int WAIT_MAX = 500;
  localparam int TXN_MAX  = 6000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  int cs_viol = 0;
  int last_high_a = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea;
  exp_t eb;

  logic [7:0] wbuf [16];

  // Instance A
  logic [7:0] tx_word_a = '0;
  logic       dv_a = 1'b0;
  logic       ready_a;
  logic [4:0] count_a = '0;
  logic       cs_a = 1'b0;
  logic       rxdv_a;
  logic [7:0] rxw_a;
  logic [4:0] rxc_a;
  logic       sclk_a, mosi_a, miso_a;
  logic [1:0] cs_n_a;
  assign miso_a = mosi_a;

  spi_master_burst #(
    .SPI_MODE(3), .CLKS_PER_HALF_BIT(4), .DATA_WIDTH(8),
    .MAX_WORDS(16), .NUM_CS(2), .CS_INACTIVE_CLKS(8)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_tx_word(tx_word_a), .i_tx_dataval(dv_a), .o_tx_ready(ready_a),
    .i_tx_count(count_a), .i_cs_sel(cs_a),
    .o_rx_dataval(rxdv_a), .o_rx_word(rxw_a), .o_rx_count(rxc_a),
    .o_SPI_clk(sclk_a), .i_SPI_MISO(miso_a), .o_SPI_MOSI(mosi_a), .o_SPI_CS_n(cs_n_a)
  );

  // Instance B
  logic [15:0] tx_word_b = '0;
  logic        dv_b = 1'b0;
  logic        ready_b;
  logic [4:0]  count_b = '0;
  logic [1:0]  cs_b = '0;
  logic        rxdv_b;
  logic [15:0] rxw_b;
  logic [4:0]  rxc_b;
  logic        sclk_b, mosi_b, miso_b;
  logic [2:0]  cs_n_b;
  assign miso_b = mosi_b;

  spi_master_burst #(
    .SPI_MODE(0), .CLKS_PER_HALF_BIT(4), .DATA_WIDTH(16),
    .MAX_WORDS(16), .NUM_CS(3), .CS_INACTIVE_CLKS(8)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_tx_word(tx_word_b), .i_tx_dataval(dv_b), .o_tx_ready(ready_b),
    .i_tx_count(count_b), .i_cs_sel(cs_b),
    .o_rx_dataval(rxdv_b), .o_rx_word(rxw_b), .o_rx_count(rxc_b),
    .o_SPI_clk(sclk_b), .i_SPI_MISO(miso_b), .o_SPI_MOSI(mosi_b), .o_SPI_CS_n(cs_n_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic check_true(input string name, input bit ok, input int act, input int req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string msg);
    n_tests++;
    n_fail++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (rxdv_a) begin
      if (q_a.size() == 0) begin
        fail_now("rx_a_unexpected", $sformatf("word %0h arrived, none expected", rxw_a));
      end else begin
        ea = q_a.pop_front();
        check("rx_a_word", 32'(rxw_a), ea.word);
        check("rx_a_count", 32'(rxc_a), ea.idx);
      end
    end
    if (rxdv_b) begin
      if (q_b.size() == 0) begin
        fail_now("rx_b_unexpected", $sformatf("word %0h arrived, none expected", rxw_b));
      end else begin
        eb = q_b.pop_front();
        check("rx_b_word", 32'(rxw_b), eb.word);
        check("rx_b_count", 32'(rxc_b), eb.idx);
      end
    end
    if ($countones(~cs_n_a) > 1 || $countones(~cs_n_b) > 1) cs_viol++;
  end

  task automatic wait_ready_a(input string name);
    for (int i = 0; i < WAIT_MAX; i++) begin
      if (ready_a) return;
      @(negedge clk);
    end
    fail_now(name, "o_tx_ready never rose");
  endtask

  task automatic wait_ready_b(input string name);
    for (int i = 0; i < WAIT_MAX; i++) begin
      if (ready_b) return;
      @(negedge clk);
    end
    fail_now(name, "o_tx_ready never rose");
  endtask

  task automatic pulse_a(input logic [7:0] w, input logic [4:0] c, input logic s);
    tx_word_a = w; count_a = c; cs_a = s; dv_a = 1'b1;
    @(negedge clk);
    dv_a = 1'b0;
  endtask

  task automatic pulse_b(input logic [15:0] w, input logic [4:0] c, input logic [1:0] s);
    tx_word_b = w; count_b = c; cs_b = s; dv_b = 1'b1;
    @(negedge clk);
    dv_b = 1'b0;
  endtask

  // One burst on instance A to select 0: sends n_send words from wbuf,
  // expects n_exp looped-back words, watches CS for the whole window.
  task automatic txn_a(input string tag, input int n_send, input logic [4:0] cnt,
                       input int n_exp, input bit inject, input bit chk_gap);
    int k;
    int rx_seen;
    logic [1:0] seen_pat;
    for (int i = 0; i < n_exp; i++) q_a.push_back('{word: 32'(wbuf[i]), idx: 32'(i)});
    fork
      begin
        for (int i = 0; i < n_send; i++) begin
          wait_ready_a({tag, "_ready"});
          pulse_a(wbuf[i], cnt, 1'b0);
        end
      end
      begin
        if (inject) begin
          repeat (30) @(negedge clk);
          check({tag, "_busy_ready"}, 32'(ready_a), 32'd0);
          pulse_a(8'hFF, 5'd1, 1'b0);
        end
      end
      begin
        k = 0;
        while (cs_n_a == 2'b11 && k < 400) begin @(negedge clk); k++; end
        if (cs_n_a == 2'b11) begin
          fail_now({tag, "_cs_assert"}, "CS_n never went low");
        end else begin
          if (chk_gap)
            check_true({tag, "_cs_gap"}, (cyc - last_high_a) >= 8, cyc - last_high_a, 8);
          seen_pat = 2'b10;
          rx_seen  = 0;
          k = 0;
          while (cs_n_a != 2'b11 && k < TXN_MAX) begin
            if (cs_n_a != 2'b10) seen_pat = cs_n_a;
            if (rxdv_a) rx_seen++;
            @(negedge clk);
            k++;
          end
          check({tag, "_cs_pattern"}, 32'(seen_pat), 32'h2);
          check({tag, "_rx_in_window"}, 32'(rx_seen), 32'(n_exp));
          check({tag, "_cs_release"}, 32'(cs_n_a), 32'h3);
          last_high_a = cyc;
        end
      end
    join
  endtask

  initial begin : stim
    int k;
    int e;
    int t1;
    int t2;
    int bad_cs;
    int bad_clk;
    int bad_rdy;
    logic prev;
    logic prev_mosi;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_a_sclk", 32'(sclk_a), 32'h1);
    check("rst_a_cs_n", 32'(cs_n_a), 32'h3);
    check("rst_a_mosi", 32'(mosi_a), 32'h0);
    check("rst_a_ready", 32'(ready_a), 32'h0);
    check("rst_a_rxdv", 32'(rxdv_a), 32'h0);
    check("rst_a_rxword", 32'(rxw_a), 32'h0);
    check("rst_a_rxcount", 32'(rxc_a), 32'h0);
    check("rst_b_sclk", 32'(sclk_b), 32'h0);
    check("rst_b_cs_n", 32'(cs_n_b), 32'h7);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(ready_a), 32'h1);

    // Single word, mode 3
    wbuf[0] = 8'hC1;
    txn_a("w1", 1, 5'd1, 1, 1'b0, 1'b0);

    // Three-word burst
    wbuf[0] = 8'hBE; wbuf[1] = 8'hEF; wbuf[2] = 8'h01;
    txn_a("w3", 3, 5'd3, 3, 1'b0, 1'b0);

    // Count 0 behaves as 1
    wbuf[0] = 8'h96;
    txn_a("cnt0", 1, 5'd0, 1, 1'b0, 1'b0);

    // Count above MAX_WORDS is capped at 16
    for (int i = 0; i < 16; i++) wbuf[i] = 8'(8'h11 * i + 3);
    txn_a("cnt20", 16, 5'd20, 16, 1'b0, 1'b0);

    // Request during SHIFT is ignored, then an immediate follow-up burst
    wbuf[0] = 8'h3C;
    txn_a("inject", 1, 5'd1, 1, 1'b1, 1'b0);
    wbuf[0] = 8'hA7;
    txn_a("b2b", 1, 5'd1, 1, 1'b0, 1'b1);

    // Reset in the middle of 0x5A
    wait_ready_a("rst_mid_ready");
    pulse_a(8'h5A, 5'd1, 1'b0);
    prev = sclk_a; e = 0; k = 0;
    while (e < 3 && k < 500) begin
      @(negedge clk);
      if (sclk_a != prev) e++;
      prev = sclk_a;
      k++;
    end
    check("rst_mid_edges", 32'(e), 32'd3);
    rst_n = 1'b0;
    #1;
    check("rst_mid_cs_n", 32'(cs_n_a), 32'h3);
    check("rst_mid_sclk", 32'(sclk_a), 32'h1);
    check("rst_mid_rxdv", 32'(rxdv_a), 32'h0);
    check("rst_mid_rxword", 32'(rxw_a), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    wbuf[0] = 8'h3C;
    txn_a("post_rst", 1, 5'd1, 1, 1'b0, 1'b0);

    // Mode 0, 16-bit on instance B
    q_b.push_back('{word: 32'hA55A, idx: 32'd0});
    wait_ready_b("m0_ready");
    pulse_b(16'hA55A, 5'd1, 2'd0);
    prev_mosi = mosi_b; k = 0;
    while (sclk_b == 1'b0 && k < 200) begin
      prev_mosi = mosi_b;
      @(negedge clk);
      k++;
    end
    check("m0_mosi_before_edge", 32'(prev_mosi), 32'h1);
    check("m0_mosi_at_edge", 32'(mosi_b), 32'h1);
    check("m0_cs_n", 32'(cs_n_b), 32'h6);
    t1 = cyc; k = 0;
    while (sclk_b == 1'b1 && k < 50) begin @(negedge clk); k++; end
    while (sclk_b == 1'b0 && k < 100) begin @(negedge clk); k++; end
    t2 = cyc;
    check("m0_sclk_period", 32'(t2 - t1), 32'd8);
    k = 0;
    while (cs_n_b != 3'b111 && k < TXN_MAX) begin @(negedge clk); k++; end
    check("m0_cs_release", 32'(cs_n_b), 32'h7);

    // Out-of-range select is ignored
    wait_ready_b("badcs_ready");
    pulse_b(16'h1234, 5'd1, 2'd3);
    bad_cs = 0; bad_clk = 0; bad_rdy = 0;
    for (int i = 0; i < 40; i++) begin
      if (cs_n_b != 3'b111) bad_cs++;
      if (sclk_b != 1'b0) bad_clk++;
      if (ready_b != 1'b1) bad_rdy++;
      @(negedge clk);
    end
    check("badcs_cs_cycles", 32'(bad_cs), 32'd0);
    check("badcs_sclk_cycles", 32'(bad_clk), 32'd0);
    check("badcs_notready_cycles", 32'(bad_rdy), 32'd0);

    repeat (10) @(negedge clk);
    check("cs_onehot_violations", 32'(cs_viol), 32'd0);
    check("q_a_left", 32'(q_a.size()), 32'd0);
    check("q_b_left", 32'(q_b.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
